reg_readback: RTL

- Read-side counterpart of the per-bit write-enabled register bank (CE/DI writes).
- On request, snapshots one WIDTH-bit word from the bank's parallel outputs, then streams it out serially, MSB first, with a valid/ready handshake.
- Appends one even-parity bit after the data bits.
- Used for debug/safety readback of DLX boost/LUT configuration registers without disturbing the writer.

---
 rtl/dlx_dbg_pkg.sv | 27 ++
 rtl/rr_shifter.sv | 50 +++++
 rtl/reg_readback.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dlx_dbg_pkg.sv
// Shared types and helpers for the DLX debug readback path: FSM encoding,
// parity mode and a constant clog2.
package dlx_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAR   = 2'b10
  } rr_state_e;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_mode_e;

  localparam parity_mode_e PARITY_MODE = EVEN;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_shifter.sv
// Parallel-load, shift-left word register with its transferred-bit counter.
// Clear has priority over load, and load has priority over shift.
module rr_shifter
  import dlx_dbg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign msb_o = shreg_q[WIDTH-1];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_readback.sv
// Snapshots one word of the register bank on request and streams it MSB first,
// followed by one parity bit, over a valid/ready serial link.
module reg_readback
  import dlx_dbg_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ,
  input  logic [ADDR_W-1:0]      ADDR,
  input  logic                   ABORT,
  input  logic [NREGS*WIDTH-1:0] BANK_DO,
  output logic                   SDO,
  output logic                   SVALID,
  input  logic                   SREADY,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   REQ_DROP,
  output rr_state_e              DBG_STATE
);

  // Handshake: a bit moves on a rising CLK edge where SVALID && SREADY && !ABORT;
  // while SREADY is low SDO and the state hold, and ABORT overrides a transfer.

  localparam int                CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [ADDR_W:0]   NREGS_L  = (ADDR_W + 1)'(NREGS);

  rr_state_e        state_q, state_d;
  logic             par_q, par_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] sel_word;
  logic             addr_ok;
  logic             load, shift, clear;
  logic             msb;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (ADDR == ADDR_W'(i)) sel_word = BANK_DO[i*WIDTH +: WIDTH];
    end
  end

  assign addr_ok = ({1'b0, ADDR} < NREGS_L);

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    done_d  = 1'b0;
    drop_d  = REQ && ((state_q != IDLE) || !addr_ok);
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ && addr_ok) begin
          load    = 1'b1;
          par_d   = (^sel_word) ^ (PARITY_MODE == ODD);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ABORT) begin
          clear   = 1'b1;
          par_d   = 1'b0;
          state_d = IDLE;
        end else if (SREADY) begin
          shift = 1'b1;
          if (cnt == LAST_IDX) state_d = PAR;
        end
      end
      PAR: begin
        if (ABORT) begin
          clear   = 1'b1;
          par_d   = 1'b0;
          state_d = IDLE;
        end else if (SREADY) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  rr_shifter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk_i   (CLK),
    .rst_n_i (RST),
    .load_i  (load),
    .shift_i (shift),
    .clear_i (clear),
    .data_i  (sel_word),
    .msb_o   (msb),
    .cnt_o   (cnt)
  );

  assign SVALID    = (state_q != IDLE);
  assign BUSY      = (state_q != IDLE);
  assign SDO       = (state_q == SHIFT) ? msb : ((state_q == PAR) ? par_q : 1'b0);
  assign DONE      = done_q;
  assign REQ_DROP  = drop_q;
  assign DBG_STATE = state_q;

endmodule
